// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the pipeline control block.
//   hz_state_t : hazard sequencer states
//   XZR        : architectural zero register; writes to it never create a hazard
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LUH_STALL = 2'd1,
        MEM_WAIT  = 2'd2
    } hz_state_t;

    localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating event counter used for the stall/flush performance counters.
// Ports:
//   clk, reset : clock and synchronous active-high clear
//   inc        : count this cycle
//   count      : current value; holds at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Detects load-use hazards, flushes the wrong-path fetch after a taken branch
// and freezes the pipeline while a data-memory access is outstanding.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   Rn_ID, Bin_ID, usesA/B_ID   : ID-stage source registers and their use flags
//   BrTaken_ID                  : raw branch decision from ID
//   Rd_EX, RegWrite_EX, MemToReg_EX : EX-stage destination info
//   memReq_MEM, memAck          : data-memory handshake
//   pc_en, ifid_en, idex_en, exmem_en : pipeline register enables
//   ifid_flush, idex_bubble, memwr_bubble : bubble/flush controls
//   BrTaken_gated               : branch decision suppressed while stalled
//   mem_err                     : sticky memory-timeout flag
//   stall_cnt, flush_cnt        : saturating performance counters
//
// state     | meaning
// RUN       | normal flow; hazards evaluated
// LUH_STALL | one bubble inserted for a load-use; load now reachable by forwarding
// MEM_WAIT  | pipeline frozen until memAck or timeout
module hazard_stall_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DELAY_SLOT  = 0,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rn_ID,
    input  logic [4:0]       Bin_ID,
    input  logic             usesA_ID,
    input  logic             usesB_ID,
    input  logic             BrTaken_ID,
    input  logic [4:0]       Rd_EX,
    input  logic             RegWrite_EX,
    input  logic             MemToReg_EX,
    input  logic             memReq_MEM,
    input  logic             memAck,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwr_bubble,
    output logic             BrTaken_gated,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    hz_state_t         state, state_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_nx;
    logic              luh, mw;
    logic              use_mw, use_luh, abort;

    assign luh = MemToReg_EX && RegWrite_EX && (Rd_EX != XZR)
              && ((usesA_ID && (Rn_ID == Rd_EX)) || (usesB_ID && (Bin_ID == Rd_EX)));
    assign mw  = memReq_MEM && !memAck;

    always_comb begin
        use_mw  = 1'b0;
        use_luh = 1'b0;
        abort   = 1'b0;
        // Decide which hazard terms this state honours; the output
        // decode below is shared so every unfreeze path behaves like RUN.
        case (state)
            RUN: begin
                use_mw  = mw;
                use_luh = luh;
            end
            LUH_STALL: begin
                use_mw = mw;
            end
            MEM_WAIT: begin
                if (memAck) begin
                    use_luh = luh;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    abort   = 1'b1;
                    use_luh = luh;
                end else begin
                    use_mw = 1'b1;
                end
            end
            default: ;
        endcase

        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        memwr_bubble  = 1'b0;
        BrTaken_gated = BrTaken_ID;
        state_nx      = RUN;
        wait_nx       = wait_cnt;

        if (use_mw) begin
            pc_en         = 1'b0;
            ifid_en       = 1'b0;
            idex_en       = 1'b0;
            exmem_en      = 1'b0;
            memwr_bubble  = 1'b1;
            BrTaken_gated = 1'b0;
            state_nx      = MEM_WAIT;
            wait_nx       = (state == MEM_WAIT) ? wait_cnt + WAIT_W'(1) : WAIT_W'(1);
        end else if (use_luh) begin
            pc_en         = 1'b0;
            ifid_en       = 1'b0;
            idex_bubble   = 1'b1;
            BrTaken_gated = 1'b0;
            state_nx      = LUH_STALL;
        end else if (BrTaken_ID && (DELAY_SLOT == 0)) begin
            ifid_flush = 1'b1;
        end

        // The timed-out access must not retire a register write.
        if (abort) begin
            memwr_bubble = 1'b1;
        end

        if (reset) begin
            pc_en         = 1'b0;
            ifid_en       = 1'b0;
            idex_en       = 1'b0;
            exmem_en      = 1'b0;
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            memwr_bubble  = 1'b1;
            BrTaken_gated = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            if (abort) begin
                mem_err <= 1'b1;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!pc_en && !reset),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ifid_flush && !reset),
        .count (flush_cnt)
    );

endmodule
